// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit active-low 7-segment driver with a per-frame input snapshot,
// leading-zero blanking and per-digit decimal points.
module seg7_scan_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(REFRESH_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [3:0]    dp_shadow;

  logic          load;
  logic [15:0]   eff_bcd;
  logic [3:0]    eff_dp;
  logic [3:0]    nib;
  logic [3:0]    blank;
  logic [6:0]    seg_dec;
  logic [3:0]    next_an;
  logic [6:0]    next_seg;
  logic          next_dp;

  // The snapshot is bypassed on the load cycle so the first digit of a frame already uses fresh data.
  always_comb begin
    load     = (tick_cnt == '0) && (idx == 2'd0);
    eff_bcd  = load ? bcd_in : shadow;
    eff_dp   = load ? dp_in  : dp_shadow;
    nib      = eff_bcd[{idx, 2'b00} +: 4];

    blank[3] = (BLANK_LEADING != 0) && (eff_bcd[15:12] == 4'd0) && !eff_dp[3];
    blank[2] = blank[3] && (eff_bcd[11:8] == 4'd0) && !eff_dp[2];
    blank[1] = blank[2] && (eff_bcd[7:4]  == 4'd0) && !eff_dp[1];
    blank[0] = 1'b0;

    case (nib)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;
    endcase

    next_an  = 4'b1111;
    next_seg = 7'b1111111;
    next_dp  = 1'b1;
    if (!blank[idx]) begin
      next_an  = ~(4'b0001 << idx);
      next_seg = seg_dec;
      next_dp  = ~eff_dp[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt    <= '0;
      idx         <= 2'd0;
      shadow      <= 16'h0000;
      dp_shadow   <= 4'b0000;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (tick_cnt == TICK_MAX) begin
        tick_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (load) begin
        shadow    <= bcd_in;
        dp_shadow <= dp_in;
      end
      an          <= next_an;
      seg         <= next_seg;
      dp          <= next_dp;
      frame_start <= load;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (blanking off/on) checked every cycle against a
// frame-level model, plus directed literal checks of the displayed digits.
module tb_seg7_scan_driver;

  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;

  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, fs0, fs1;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [16];

  // Model state: snapshot of the current frame and which digit the outputs show.
  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic [15:0] m_snap = 16'h0;
  logic [3:0]  m_dpsnap = 4'h0;
  int          m_digit = 0;
  logic        m_fs = 1'b0;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(0)) dut0 (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in),
    .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0)
  );

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(1)) dut1 (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in),
    .an(an1), .seg(seg1), .dp(dp1), .frame_start(fs1)
  );

  always #5 clk = ~clk;

  // Cycle c after release shows digit (c/RD)%4 of the snapshot taken at the last frame boundary.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_fs    <= 1'b0;
    end else begin
      if (m_cnt % FRAME == 0) begin
        m_snap   <= bcd_in;
        m_dpsnap <= dp_in;
      end
      m_digit <= (m_cnt / RD) % 4;
      m_fs    <= (m_cnt % FRAME == 0);
      m_cnt   <= m_cnt + 1;
      m_valid <= 1'b1;
    end
  end

  function automatic logic [11:0] expected(input int blank_en);
    logic [3:0] nib;
    logic       blanked;
    logic [3:0] ean;
    nib = m_snap[4*m_digit +: 4];
    blanked = (blank_en != 0) && (m_digit != 0) &&
              ((m_snap >> (4*m_digit)) == 16'h0) && ((m_dpsnap >> m_digit) == 4'h0);
    ean = 4'b1111;
    ean[m_digit] = 1'b0;
    if (blanked) return {4'b1111, 7'b1111111, 1'b1};
    return {ean, seg_tab[nib], ~m_dpsnap[m_digit]};
  endfunction

  task automatic checkOne(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got an/seg/dp/fs=%b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic compareModel();
    if (rst) begin
      checkOne("reset0", {an0, seg0, dp0, fs0}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
      checkOne("reset1", {an1, seg1, dp1, fs1}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
    end else if (m_valid) begin
      checkOne("model0", {an0, seg0, dp0, fs0}, {expected(0), m_fs});
      checkOne("model1", {an1, seg1, dp1, fs1}, {expected(1), m_fs});
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    compareModel();
  endtask

  task automatic waitEdges(input int n);
    repeat (n) stepCycle();
  endtask

  task automatic checkOutput(input string name, input int which,
                             input logic [3:0] ean, input logic [6:0] eseg, input logic edp);
    if (which == 0) checkOne(name, {an0, seg0, dp0, 1'b0}, {ean, eseg, edp, 1'b0});
    else            checkOne(name, {an1, seg1, dp1, 1'b0}, {ean, eseg, edp, 1'b0});
  endtask

  task automatic checkFs(input string name, input logic efs);
    checkOne(name, {12'h0, fs0}, {12'h0, efs});
  endtask

  // Holds reset for three cycles with the new inputs applied; returns just after release.
  task automatic applyStimulus(input logic [15:0] bcd, input logic [3:0] dpv);
    rst    = 1'b1;
    bcd_in = bcd;
    dp_in  = dpv;
    repeat (3) stepCycle();
    checkOutput("reset_hold", 1, 4'b1111, 7'b1111111, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    // Scan order and timing with blanking disabled.
    applyStimulus(16'h1234, 4'b0000);
    waitEdges(1);
    checkOutput("scan_d0", 0, 4'b1110, 7'b0011001, 1'b1);
    checkFs("fs_first", 1'b1);
    waitEdges(1);
    checkFs("fs_low", 1'b0);
    waitEdges(3);
    checkOutput("scan_d1", 0, 4'b1101, 7'b0110000, 1'b1);
    waitEdges(4);
    checkOutput("scan_d2", 0, 4'b1011, 7'b0100100, 1'b1);
    waitEdges(4);
    checkOutput("scan_d3", 0, 4'b0111, 7'b1111001, 1'b1);
    waitEdges(4);
    checkFs("fs_period", 1'b1);
    checkOutput("scan_wrap", 0, 4'b1110, 7'b0011001, 1'b1);

    // Leading-zero blanking.
    applyStimulus(16'h0042, 4'b0000);
    waitEdges(1);
    checkOutput("blank_d0", 1, 4'b1110, 7'b0100100, 1'b1);
    waitEdges(4);
    checkOutput("blank_d1", 1, 4'b1101, 7'b0011001, 1'b1);
    waitEdges(4);
    checkOutput("blank_d2", 1, 4'b1111, 7'b1111111, 1'b1);
    waitEdges(4);
    checkOutput("blank_d3", 1, 4'b1111, 7'b1111111, 1'b1);

    applyStimulus(16'h0000, 4'b0000);
    waitEdges(1);
    checkOutput("zero_d0", 1, 4'b1110, 7'b1000000, 1'b1);
    waitEdges(4);
    checkOutput("zero_d1", 1, 4'b1111, 7'b1111111, 1'b1);
    waitEdges(12);

    // Decimal point keeps its digit and the zeros below it lit.
    applyStimulus(16'h0005, 4'b0100);
    waitEdges(1);
    checkOutput("dp_d0", 1, 4'b1110, 7'b0010010, 1'b1);
    waitEdges(4);
    checkOutput("dp_d1", 1, 4'b1101, 7'b1000000, 1'b1);
    waitEdges(4);
    checkOutput("dp_d2", 1, 4'b1011, 7'b1000000, 1'b0);
    waitEdges(4);
    checkOutput("dp_d3", 1, 4'b1111, 7'b1111111, 1'b1);

    // Input changes mid-frame must not reach the display until the next frame.
    applyStimulus(16'h0099, 4'b0000);
    waitEdges(5);
    checkOutput("tear_d1_old", 1, 4'b1101, 7'b0010000, 1'b1);
    bcd_in = 16'h0100;
    waitEdges(2);
    checkOutput("tear_d1_hold", 1, 4'b1101, 7'b0010000, 1'b1);
    waitEdges(2);
    checkOutput("tear_d2_old", 1, 4'b1111, 7'b1111111, 1'b1);
    waitEdges(8);
    checkOutput("tear_d0_new", 1, 4'b1110, 7'b1000000, 1'b1);
    waitEdges(4);
    checkOutput("tear_d1_new", 1, 4'b1101, 7'b1000000, 1'b1);
    waitEdges(4);
    checkOutput("tear_d2_new", 1, 4'b1011, 7'b1111001, 1'b1);

    // Invalid BCD shows a dash and counts as non-zero for blanking.
    applyStimulus(16'hA00F, 4'b0000);
    waitEdges(1);
    checkOutput("inv_d0", 1, 4'b1110, 7'b0111111, 1'b1);
    waitEdges(4);
    checkOutput("inv_d1", 1, 4'b1101, 7'b1000000, 1'b1);
    waitEdges(4);
    checkOutput("inv_d2", 1, 4'b1011, 7'b1000000, 1'b1);
    waitEdges(4);
    checkOutput("inv_d3", 1, 4'b0111, 7'b0111111, 1'b1);

    // Asynchronous reset between edges, then a clean restart with a fresh snapshot.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst0", 0, 4'b1111, 7'b1111111, 1'b1);
    checkOutput("async_rst1", 1, 4'b1111, 7'b1111111, 1'b1);
    bcd_in = 16'h0042;
    waitEdges(2);
    rst = 1'b0;
    waitEdges(1);
    checkOutput("restart_d0", 1, 4'b1110, 7'b0100100, 1'b1);
    checkFs("restart_fs", 1'b1);
    waitEdges(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
